// File: rtl/instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Instruction fetch stage placed directly in front of the core's instruction
// input. It issues sequential word fetches on the instruction memory bus,
// keeps the returned words together with their PCs in a small in-order FIFO,
// and hands one instruction at a time to the core over a valid/ready
// handshake. A redirect flushes the FIFO, marks every in-flight response as
// stale and restarts fetching at the new (word-aligned) PC.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_req_o         fetch request (held stable with its address until grant)
//   mem_addr_o        word-aligned fetch address
//   mem_gnt_i         request accepted this cycle
//   mem_rvalid_i      in-order response valid
//   mem_rdata_i       response instruction word
//   instr_valid_o     FIFO head valid (forced low during a redirect)
//   instr_o           FIFO head instruction
//   instr_pc_o        PC of the FIFO head
//   instr_ready_i     core consumes the head when high with instr_valid_o
//   redirect_i        flush and restart fetch
//   redirect_pc_i     new fetch PC, bits [1:0] ignored
//   count_o           number of valid FIFO entries
// -----------------------------------------------------------------------------
module instr_prefetch_buffer #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DAT_WIDTH  = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,

  output logic                     mem_req_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DAT_WIDTH-1:0]     mem_rdata_i,

  output logic                     instr_valid_o,
  output logic [DAT_WIDTH-1:0]     instr_o,
  output logic [ADDR_WIDTH-1:0]    instr_pc_o,
  input  logic                     instr_ready_i,

  input  logic                     redirect_i,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,

  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  started_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be accepted into the FIFO.
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic [CntW-1:0]       discard_q, discard_d;

  logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DAT_WIDTH-1:0]  instr_mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [CntW:0]         occupancy;
  logic                  has_credit;
  logic                  gnt_fire;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
  logic                  unused_redirect_pc_bits;

  // Stale in-flight responses still hold credit, so a push can never find
  // the FIFO full.
  assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
  assign has_credit = occupancy < (CntW + 1)'(DEPTH);

  // Credit cannot drop while a request waits: pops only free space and a
  // push moves one unit from inflight to count.
  assign mem_req_o  = started_q & ~redirect_i & has_credit;
  assign mem_addr_o = fetch_pc_q;
  assign gnt_fire   = mem_req_o & mem_gnt_i;

  assign instr_valid_o = (count_q != '0) & ~redirect_i;
  assign instr_o       = instr_mem_q[rptr_q];
  assign instr_pc_o    = pc_mem_q[rptr_q];
  assign count_o       = count_q;

  assign pop  = instr_valid_o & instr_ready_i;
  // Responses arriving in a redirect cycle, or while stale ones remain, are dropped.
  assign push = mem_rvalid_i & ~redirect_i & (discard_q == '0);

  assign redirect_pc_aligned     = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_pc_bits = ^redirect_pc_i[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CntW'(gnt_fire) - CntW'(mem_rvalid_i);

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      // Everything still outstanding after this cycle belongs to the old path.
      discard_d  = inflight_d;
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (mem_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - CntW'(1);
      end
      if (push) begin
        wptr_d    = wptr_q + PtrW'(1);
        resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      // First edge after reset release enables fetching.
      started_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (cleared on reset so the head reads as zero)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wptr_q]    <= resp_pc_q;
      instr_mem_q[wptr_q] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  count_o;

  instr_prefetch_buffer #(
    .ADDR_WIDTH (32),
    .DAT_WIDTH  (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: outstanding requests as a queue of tagged addresses,
  // delivered instructions as a queue of {pc, word}.
  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  req_t        pend[$];
  ent_t        fq[$];
  bit          m_started;
  logic [31:0] m_fetch_pc;
  int          cyc;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Bus behaviour knobs
  int p_gnt = 100, p_rv = 100, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got timeout expected event at %0t", nm, $time);
  endtask

  task automatic model_reset();
    fq.delete();
    pend.delete();
    m_started  = 0;
    m_fetch_pc = 32'h0;
    cyc        = 0;
  endtask

  // Advance the model over one rising edge using the inputs of the ending cycle.
  task automatic model_update();
    req_t r;
    ent_t e;
    bit   e_req, e_valid;
    e_req   = m_started && !redirect && (fq.size() + pend.size() < DEPTH);
    e_valid = (fq.size() != 0) && !redirect;
    if (e_valid && instr_ready) e = fq.pop_front();
    if (mem_rvalid && pend.size() > 0) begin
      r = pend.pop_front();
      if (!redirect && !r.stale) begin
        e.pc  = r.addr;
        e.ins = mem_word(r.addr);
        fq.push_back(e);
      end
    end
    if (e_req && mem_gnt) begin
      r.addr  = m_fetch_pc;
      r.stale = 0;
      r.due   = cyc + $urandom_range(lat_max, lat_min);
      pend.push_back(r);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redirect) begin
      fq.delete();
      foreach (pend[i]) pend[i].stale = 1;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end
    m_started = 1;
    cyc++;
  endtask

  // Bus: in-order responses, each no earlier than the cycle after its grant.
  task automatic drive_bus();
    mem_gnt = ($urandom_range(99) < p_gnt);
    if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < p_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    model_update();
    #1;
    drive_bus();
  endtask

  task automatic zero_wait();
    p_gnt = 100; p_rv = 100; lat_min = 1; lat_max = 1;
  endtask

  // Compare process: every cycle the DUT is out of reset.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_req, e_valid;
      e_req   = m_started && !redirect && (fq.size() + pend.size() < DEPTH);
      e_valid = (fq.size() != 0) && !redirect;
      check("mem_req", 32'(mem_req_o), 32'(e_req));
      check("mem_addr", mem_addr_o, m_fetch_pc);
      check("instr_valid", 32'(instr_valid_o), 32'(e_valid));
      check("count", 32'(count_o), 32'(fq.size()));
      if (e_valid) begin
        check("instr_pc", instr_pc_o, fq[0].pc);
        check("instr", instr_o, fq[0].ins);
      end
    end
  end

  task automatic check_reset_values(string tag);
    check({tag, "_req"}, 32'(mem_req_o), 32'h0);
    check({tag, "_addr"}, mem_addr_o, 32'h0);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'h0);
    check({tag, "_instr"}, instr_o, 32'h0);
    check({tag, "_pc"}, instr_pc_o, 32'h0);
    check({tag, "_count"}, 32'(count_o), 32'h0);
  endtask

  initial begin
    int n;
    model_reset();
    zero_wait();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");

    // Core stalled: exactly DEPTH grants then the request drops.
    rst_n = 1'b1;
    chk_en = 1;
    instr_ready = 1'b0;
    drive_bus();
    #1 check("c0_req", 32'(mem_req_o), 32'h0);
    step();
    #1 check("c1_req", 32'(mem_req_o), 32'h1);
    check("c1_addr", mem_addr_o, 32'h0);
    repeat (10) step();
    #1 check("full_count", 32'(count_o), 32'd4);
    check("full_req", 32'(mem_req_o), 32'h0);
    check("full_addr", mem_addr_o, 32'h10);
    check("full_head_pc", instr_pc_o, 32'h0);
    check("full_head_instr", instr_o, 32'h100);
    instr_ready = 1'b1;
    step();
    #1 check("resume_req", 32'(mem_req_o), 32'h1);
    check("resume_addr", mem_addr_o, 32'h10);
    repeat (20) step();

    // Three requests in flight on a 3-cycle bus, then redirect to 0x203.
    lat_min = 3; lat_max = 3;
    n = 0;
    while (pend.size() != 3 && n < 30) begin step(); n++; end
    if (n >= 30) timeout("inflight3");
    redirect = 1'b1;
    redirect_pc = 32'h203;
    #1 check("redir_req", 32'(mem_req_o), 32'h0);
    check("redir_valid", 32'(instr_valid_o), 32'h0);
    step();
    redirect = 1'b0;
    #1 check("redir_addr", mem_addr_o, 32'h200);
    n = 0;
    while (fq.size() == 0 && n < 40) begin step(); n++; end
    if (n >= 40) timeout("redir_first");
    #1 check("redir_first_pc", instr_pc_o, 32'h200);
    check("redir_first_instr", instr_o, 32'h300);

    // Address wrap at the top of the address space.
    zero_wait();
    step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    #1 check("wrap_addr0", mem_addr_o, 32'hFFFF_FFFC);
    n = 0;
    while (m_fetch_pc == 32'hFFFF_FFFC && n < 40) begin step(); n++; end
    if (n >= 40) timeout("wrap_grant");
    #1 check("wrap_addr1", mem_addr_o, 32'h0);
    n = 0;
    while (fq.size() == 0 && n < 40) begin step(); n++; end
    if (n >= 40) timeout("wrap_first");
    #1 check("wrap_pc0", instr_pc_o, 32'hFFFF_FFFC);
    check("wrap_instr0", instr_o, 32'h0000_00FC);
    step();
    n = 0;
    while (fq.size() == 0 && n < 40) begin step(); n++; end
    if (n >= 40) timeout("wrap_second");
    #1 check("wrap_pc1", instr_pc_o, 32'h0);

    // Redirect colliding with a response and a ready core at count 2.
    lat_min = 2; lat_max = 2;
    instr_ready = 1'b0;
    n = 0;
    while (!(fq.size() == 2 && mem_rvalid) && n < 40) begin step(); n++; end
    if (n >= 40) timeout("collide");
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h400;
    #1 check("collide_valid", 32'(instr_valid_o), 32'h0);
    step();
    redirect = 1'b0;
    #1 check("collide_count", 32'(count_o), 32'h0);
    n = 0;
    while (fq.size() == 0 && n < 40) begin step(); n++; end
    if (n >= 40) timeout("collide_first");
    #1 check("collide_first_pc", instr_pc_o, 32'h400);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      int p_rdy;
      if (i % 150 == 0) begin
        p_gnt   = $urandom_range(100, 30);
        p_rv    = $urandom_range(100, 40);
        lat_min = 1;
        lat_max = $urandom_range(4, 1);
      end
      p_rdy = (i % 300 < 150) ? 80 : 40;
      instr_ready = ($urandom_range(99) < p_rdy);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : $urandom;
      step();
    end
    redirect = 1'b0;

    // Asynchronous reset mid-stream with three entries buffered.
    zero_wait();
    instr_ready = 1'b0;
    n = 0;
    while (fq.size() != 3 && n < 60) begin step(); n++; end
    if (n >= 60) timeout("fill3");
    #2;
    chk_en = 0;
    rst_n = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    model_reset();
    #1 check_reset_values("arst");
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    chk_en = 1;
    drive_bus();
    #1 check("arst_c0_req", 32'(mem_req_o), 32'h0);
    step();
    #1 check("arst_c1_req", 32'(mem_req_o), 32'h1);
    check("arst_c1_addr", mem_addr_o, 32'h0);
    step();
    step();
    #1 check("arst_c3_valid", 32'(instr_valid_o), 32'h1);
    check("arst_c3_pc", instr_pc_o, 32'h0);
    check("arst_c3_instr", instr_o, 32'h100);
    step();
    #1 check("arst_c4_pc", instr_pc_o, 32'h4);
    check("arst_c4_instr", instr_o, 32'h104);
    repeat (5) step();
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
